// File: rtl/id_ex_pipe_ctrl.sv
// ID->EX stage register: valid/ready handshake, stall hold, flush-to-bubble,
// RISC-V immediate generation (I/S/B/U/J) and a saturating bubble counter.
module id_ex_pipe_ctrl #(
  parameter int XLEN     = 32,
  parameter int EX_W     = 2,
  parameter int MEM_W    = 3,
  parameter int WB_W     = 2,
  parameter bit SIGN_EXT = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  output logic             id_ready_o,
  input  logic             ex_ready_i,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  RSdata_i,
  input  logic [XLEN-1:0]  RTdata_i,
  input  logic [EX_W-1:0]  EX_signal_i,
  input  logic [MEM_W-1:0] MEM_signal_i,
  input  logic [WB_W-1:0]  WB_signal_i,
  output logic             ex_valid_o,
  output logic [31:0]      inst_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  RSdata_o,
  output logic [XLEN-1:0]  RTdata_o,
  output logic [XLEN-1:0]  RS2Data_o,
  output logic [XLEN-1:0]  ImmData_o,
  output logic             Immsig_o,
  output logic [EX_W-1:0]  EX_signal_o,
  output logic [MEM_W-1:0] MEM_signal_o,
  output logic [WB_W-1:0]  WB_signal_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
  } payload_t;

  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
  } ctrl_t;

  payload_t         pay_q, pay_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             vld_q, vld_nxt;
  logic             immsig_q, immsig_d;
  logic [CNT_W-1:0] cnt_q;
  logic             xfer, drain;

  // immediate decode
  logic            sbit, fill;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_d;

  assign sbit = SIGN_EXT ? inst_i[31] : 1'b0;

  always_comb begin
    imm32    = '0;
    fill     = 1'b0;
    immsig_d = 1'b0;
    unique case (inst_i[6:0])
      OP_LOAD, OP_IMM: begin
        imm32 = {{20{sbit}}, inst_i[31:20]};
        fill = sbit; immsig_d = 1'b1;
      end
      OP_JALR: begin
        // target adder uses the immediate; ALU operand B stays rs2
        imm32 = {{20{sbit}}, inst_i[31:20]};
        fill = sbit;
      end
      OP_STORE: begin
        imm32 = {{20{sbit}}, inst_i[31:25], inst_i[11:7]};
        fill = sbit; immsig_d = 1'b1;
      end
      OP_BRANCH: begin
        imm32 = {{19{sbit}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        fill = sbit;
      end
      OP_LUI, OP_AUIPC: begin
        imm32 = {inst_i[31:12], 12'b0};
        fill = sbit; immsig_d = 1'b1;
      end
      OP_JAL: begin
        imm32 = {{11{sbit}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        fill = sbit;
      end
      default: ;
    endcase
    imm_d        = {XLEN{fill}};
    imm_d[31:0]  = imm32;
  end

  always_comb begin
    pay_d.inst = inst_i;
    pay_d.pc   = pc_i;
    pay_d.rs1  = RSdata_i;
    pay_d.rs2  = RTdata_i;
    pay_d.imm  = imm_d;
    pay_d.opb  = immsig_d ? imm_d : RTdata_i;
    ctrl_d.ex  = EX_signal_i;
    ctrl_d.mem = MEM_signal_i;
    ctrl_d.wb  = WB_signal_i;
  end

  // handshake
  assign id_ready_o = !vld_q | ex_ready_i;
  assign xfer       = id_valid_i & id_ready_o;
  assign drain      = ex_ready_i & vld_q & ~xfer;

  always_comb begin
    vld_nxt = vld_q;
    if (flush_i)    vld_nxt = 1'b0;
    else if (xfer)  vld_nxt = 1'b1;
    else if (drain) vld_nxt = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q    <= 1'b0;
      pay_q    <= '0;
      ctrl_q   <= '0;
      immsig_q <= 1'b0;
    end else if (flush_i) begin
      // payload kept; only what can cause side effects is cleared
      vld_q    <= 1'b0;
      ctrl_q   <= '0;
      immsig_q <= 1'b0;
    end else if (xfer) begin
      vld_q    <= 1'b1;
      pay_q    <= pay_d;
      ctrl_q   <= ctrl_d;
      immsig_q <= immsig_d;
    end else if (drain) begin
      vld_q    <= 1'b0;
      ctrl_q   <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   cnt_q <= '0;
    else if (!vld_nxt && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end

  assign ex_valid_o   = vld_q;
  assign inst_o       = pay_q.inst;
  assign pc_o         = pay_q.pc;
  assign RSdata_o     = pay_q.rs1;
  assign RTdata_o     = pay_q.opb;
  assign RS2Data_o    = pay_q.rs2;
  assign ImmData_o    = pay_q.imm;
  assign Immsig_o     = immsig_q;
  assign EX_signal_o  = ctrl_q.ex;
  assign MEM_signal_o = ctrl_q.mem;
  assign WB_signal_o  = ctrl_q.wb;
  assign bubble_cnt_o = cnt_q;

endmodule
